// File: rtl/tpu_weight_loader.sv
// Weight-buffer write-port producer: unpacks ternary stream beats into rows and issues the bank swap.
// Optional zero-padding of the last row group is enabled by defining TPU_WLOAD_ZERO_PAD_EN.
module tpu_weight_loader #(
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_K      = 256,
  parameter int ADDR_WIDTH = 16,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(MAX_K):0]           num_rows,
  input  logic                             compute_idle,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [BUS_WIDTH-1:0]             s_data,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [ARRAY_SIZE-1:0][1:0]       wr_data,
  output logic                             swap_banks,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  localparam int RW  = 2*ARRAY_SIZE;
  localparam int SPB = BUS_WIDTH/RW;
  localparam int SW  = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int NRW = $clog2(MAX_K)+1;

`ifdef TPU_WLOAD_ZERO_PAD_EN
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_SWAP, FIN, PAD} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_SWAP, FIN} state_t;
`endif

  state_t                     state, state_nx;
  logic [NRW-1:0]             num_q, row_cnt;
  logic [SPB-1:0][RW-1:0]     hold;
  logic                       hold_vld;
  logic [SW-1:0]              slice_cnt;
  logic [ARRAY_SIZE-1:0][1:0] cur_row, wr_row;
  logic                       start_ok, last_slice, last_row, bad_w, pad_need;

  assign cur_row    = hold[slice_cnt];
  assign start_ok   = (num_rows != '0) && (num_rows <= NRW'(MAX_K));
  assign last_slice = (slice_cnt == SW'(SPB-1));
  assign last_row   = (row_cnt == num_q - NRW'(1));

  always_comb begin
    bad_w = 1'b0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      if (cur_row[i] == 2'b10) bad_w = 1'b1;
  end

`ifdef TPU_WLOAD_ZERO_PAD_EN
  // Pad target: num_rows rounded up to a whole row group, never past MAX_K.
  logic [NRW:0] pad_sum, pad_rnd, pad_end;
  always_comb begin
    pad_sum  = {1'b0, num_q} + (NRW+1)'(ARRAY_SIZE-1);
    pad_rnd  = (pad_sum / (NRW+1)'(ARRAY_SIZE)) * (NRW+1)'(ARRAY_SIZE);
    pad_end  = (pad_rnd > (NRW+1)'(MAX_K)) ? (NRW+1)'(MAX_K) : pad_rnd;
    pad_need = (pad_end != {1'b0, num_q});
  end
`else
  assign pad_need = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    wr_en      = 1'b0;
    wr_row     = '0;
    s_ready    = 1'b0;
    swap_banks = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_nx = start_ok ? LOAD : FIN;
      LOAD: begin
        s_ready = !hold_vld || (last_slice && !last_row);
        if (hold_vld) begin
          wr_en  = 1'b1;
          wr_row = cur_row;
          if (last_row) begin
`ifdef TPU_WLOAD_ZERO_PAD_EN
            state_nx = pad_need ? PAD : WAIT_SWAP;
`else
            state_nx = WAIT_SWAP;
`endif
          end
        end
      end
`ifdef TPU_WLOAD_ZERO_PAD_EN
      PAD: begin
        wr_en = 1'b1;
        if ({1'b0, row_cnt} == pad_end - (NRW+1)'(1)) state_nx = WAIT_SWAP;
      end
`endif
      WAIT_SWAP: if (compute_idle) begin
        swap_banks = 1'b1;
        state_nx   = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_q     <= '0;
      row_cnt   <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      slice_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        if (start_ok) begin
          num_q     <= num_rows;
          row_cnt   <= '0;
          err       <= 1'b0;
          hold_vld  <= 1'b0;
          slice_cnt <= '0;
        end else begin
          err <= 1'b1;
        end
      end
      if (wr_en) row_cnt <= row_cnt + NRW'(1);
      if (state == LOAD && hold_vld && bad_w) err <= 1'b1;
      if (s_valid && s_ready) begin
        hold      <= s_data;
        hold_vld  <= 1'b1;
        slice_cnt <= '0;
      end else if (state == LOAD && hold_vld) begin
        // Last row drops whatever slices remain in the beat.
        if (last_row || last_slice) hold_vld <= 1'b0;
        else                        slice_cnt <= slice_cnt + SW'(1);
      end
    end
  end

  assign wr_addr = ADDR_WIDTH'(row_cnt);
  assign wr_data = wr_row;
  assign busy    = (state != IDLE);

  logic unused_pad;
  assign unused_pad = pad_need;
endmodule

// File: tb/tb_tpu_weight_loader.sv
// Randomized bench for tpu_weight_loader against a queue-based write/swap/done reference model.
module tb_tpu_weight_loader;
  localparam int AS = 8, MK = 256, AW = 16, BW = 32, RW = 16, SPB = 2, NRW = 9;

  logic clk = 0, rst_n = 0, start = 0, compute_idle = 0, s_valid = 0;
  logic [NRW-1:0] num_rows = '0;
  logic [BW-1:0] s_data = '0;
  logic s_ready, wr_en, swap_banks, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [AS-1:0][1:0] wr_data;

  tpu_weight_loader #(.ARRAY_SIZE(AS), .MAX_K(MK), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .compute_idle(compute_idle),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_banks(swap_banks), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  typedef struct { int addr; logic [RW-1:0] data; } wr_t;
  wr_t expq[$];
  logic [BW-1:0] beats[$];
  int cyc = 0, wr_cnt, swap_cnt, done_cnt, acc_cnt, first_wr, last_wr, first_acc, swap_cyc, done_cyc;
  logic err_done;
  bit ignore = 0;

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (rst_n) begin
      if (s_valid && s_ready) begin
        if (acc_cnt == 0) first_acc = cyc;
        acc_cnt++;
      end
      if (wr_en) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        if (!ignore) begin
          if (expq.size() == 0) chk("spurious_wr", 1, 0);
          else begin
            e = expq.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
      end
      if (swap_banks) begin swap_cnt++; swap_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; err_done = err; end
      if (wr_en || swap_banks || done)
        chk("exclusive", int'(wr_en) + int'(swap_banks) + int'(done), 1);
    end
  end

  task automatic clr();
    wr_cnt = 0; swap_cnt = 0; done_cnt = 0; acc_cnt = 0;
    first_wr = 0; last_wr = 0; first_acc = 0; swap_cyc = 0; done_cyc = 0; err_done = 0;
  endtask

  // gap < 0 selects a random 0..3 cycle gap per beat.
  task automatic run_layer(input int n, input int gap, input int idle_dly, input int bad_row, input bit raw);
    int nb, nw, st_cyc, k;
    bit ok;
    logic exp_err;
    logic [BW-1:0] d;
    logic [RW-1:0] row;
    ok = (n >= 1 && n <= MK);
    nb = ok ? (n + SPB - 1) / SPB : 0;
    if (beats.size() == 0)
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        if (!raw) for (int i = 0; i < BW/2; i++) if (d[2*i +: 2] == 2'b10) d[2*i +: 2] = 2'b00;
        beats.push_back(d);
      end
    if (bad_row >= 0 && bad_row < n) begin
      d = beats[bad_row / SPB];
      d[(bad_row % SPB) * RW + 2 +: 2] = 2'b10;
      beats[bad_row / SPB] = d;
    end
    exp_err = !ok;
    expq.delete();
    if (ok) begin
      for (int r = 0; r < n; r++) begin
        d = beats[r / SPB];
        row = d[(r % SPB) * RW +: RW];
        for (int i = 0; i < AS; i++) if (row[2*i +: 2] == 2'b10) exp_err = 1;
        expq.push_back('{r, row});
      end
`ifdef TPU_WLOAD_ZERO_PAD_EN
      begin
        int p;
        p = ((n + AS - 1) / AS) * AS;
        if (p > MK) p = MK;
        for (int r = n; r < p; r++) expq.push_back('{r, '0});
      end
`endif
    end
    nw = expq.size();
    clr();
    compute_idle = (idle_dly == 0);
    @(posedge clk); #1 start = 1; num_rows = NRW'(n); st_cyc = cyc + 1;
    @(posedge clk); #1 start = 0;
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, !ok);
    for (int b = 0; b < nb; b++) begin
      s_valid = 1; s_data = beats[b]; k = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        if (++k > 500) begin chk("beat_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
      if (b < nb - 1) begin
        k = (gap < 0) ? $urandom_range(0, 3) : gap;
        if (k > 0) begin
          s_valid = 0; s_data = $urandom;
          repeat (k) @(posedge clk);
          #1;
        end
      end
    end
    if (ok) begin s_valid = 1; s_data = $urandom; end
    k = 0;
    while (expq.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    chk("writes_drained", expq.size(), 0);
    if (idle_dly > 0) begin
      repeat (idle_dly) @(negedge clk);
      chk("no_early_swap", swap_cnt, 0);
      @(posedge clk); #1 compute_idle = 1;
    end
    k = 0;
    while (done_cnt == 0 && k < 2000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    s_valid = 0;
    chk("done_cnt", done_cnt, 1);
    chk("swap_cnt", swap_cnt, ok);
    chk("wr_cnt", wr_cnt, nw);
    chk("beats_taken", acc_cnt, nb);
    chk("err_at_done", err_done, exp_err);
    chk("err_sticky", err, exp_err);
    chk("busy_end", busy, 0);
    if (ok) begin
      chk("swap_to_done", done_cyc - swap_cyc, 1);
      chk("first_wr_lat", first_wr - first_acc, 1);
      if (gap == 0) chk("contiguous", last_wr - first_wr, nw - 1);
      if (idle_dly > 0) chk("swap_after_idle", swap_cyc > last_wr + idle_dly, 1);
    end else begin
      chk("err_done_lat", done_cyc - st_cyc, 1);
    end
    beats.delete();
  endtask

  initial begin
    clr();
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_swap", swap_banks, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    beats.push_back(32'h0000_5555); beats.push_back(32'hFFFF_0F0F);
    run_layer(4, 0, 0, -1, 0);
    beats.push_back(32'h0000_1111); beats.push_back(32'hAAAA_5555);
    run_layer(3, 0, 0, -1, 0);
    run_layer(8, 3, 0, -1, 0);
    run_layer(5, 0, 10, -1, 0);
    run_layer(0, 0, 0, -1, 0);
    run_layer(2, 0, 0, -1, 0);
    run_layer(257, 0, 0, -1, 0);
    run_layer(6, 0, 0, 4, 0);
    run_layer(MK, 0, 0, -1, 0);

    // Abort a load with reset after an illegal row has set err.
    ignore = 1; clr(); compute_idle = 1;
    @(posedge clk); #1 start = 1; num_rows = NRW'(20);
    @(posedge clk); #1 start = 0; s_valid = 1; s_data = 32'hAAAA_AAAA;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_addr", wr_addr, 0);
    s_valid = 0;
    @(posedge clk); #1 rst_n = 1; ignore = 0; clr();
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", wr_cnt + swap_cnt + done_cnt, 0);

    for (int t = 0; t < 8; t++)
      run_layer($urandom_range(1, 40), -1, $urandom_range(0, 4),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 39) : -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
